// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a combinational single-port
// memory: one access per two cycles, write strobe held for exactly one cycle.
module mem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ready,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ready,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in,
    output logic          mem_read,
    input  logic [DW-1:0] mem_out
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]    state_reg;
    logic          prio_reg;      // port that wins when both request
    logic          port_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic          mem_read_reg;

    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [1:0]    ready_vec;
    logic [AW-1:0] addr_arr  [2];
    logic [DW-1:0] wdata_arr [2];
    logic          accept;
    logic          grant_port;

    assign req_vec      = {p1_req, p0_req};
    assign we_vec       = {p1_we, p0_we};
    assign addr_arr[0]  = p0_addr;
    assign addr_arr[1]  = p1_addr;
    assign wdata_arr[0] = p0_wdata;
    assign wdata_arr[1] = p1_wdata;

    always_comb begin
        accept     = (state_reg == IDLE) && (|req_vec);
        grant_port = (&req_vec) ? prio_reg : req_vec[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            prio_reg     <= 1'b0;
            port_reg     <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            mem_read_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg     <= addr_arr[grant_port];
                        wdata_reg    <= we_vec[grant_port] ? wdata_arr[grant_port] : '0;
                        mem_read_reg <= we_vec[grant_port];
                        port_reg     <= grant_port;
                        we_reg       <= we_vec[grant_port];
                        prio_reg     <= ~grant_port;
                        state_reg    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Address is kept so the memory output stays stable after the access.
                    mem_read_reg <= 1'b0;
                    wdata_reg    <= '0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : port_gen
        localparam logic PID = (gi == 1);
        logic          done_reg;
        logic [DW-1:0] rdata_reg;
        logic          finish;

        assign finish        = (state_reg == ACCESS) && (port_reg == PID);
        assign ready_vec[gi] = accept && (grant_port == PID);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                done_reg  <= 1'b0;
                rdata_reg <= '0;
            end else begin
                done_reg <= finish;
                if (finish && !we_reg) begin
                    rdata_reg <= mem_out;
                end
            end
        end
    end

    assign p0_ready    = ready_vec[0];
    assign p1_ready    = ready_vec[1];
    assign p0_done     = port_gen[0].done_reg;
    assign p1_done     = port_gen[1].done_reg;
    assign p0_rdata    = port_gen[0].rdata_reg;
    assign p1_rdata    = port_gen[1].rdata_reg;
    assign mem_address = addr_reg;
    assign mem_in      = wdata_reg;
    assign mem_read    = mem_read_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps plus random traffic, checked against a
// transaction-level model of arbitration, latency and memory contents.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p0_ready, p0_done, p1_ready, p1_done;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_in, mem_out;
    logic          mem_read;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_in(mem_in), .mem_read(mem_read),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write lands at the end of the strobe cycle.
    logic [DW-1:0] mem [32];
    assign mem_out = mem[mem_address];
    always @(posedge clk) if (mem_read) mem[mem_address] <= mem_in;

    // Reference model state
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_rdata [2];
    int            cyc = 0;
    bit            pend_valid = 1'b0;
    int            pend_due, pend_port;
    bit            pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_wdata, pend_rdata;
    int            last_grant = 1;
    int            grants[$];
    int            passed = 0;
    int            total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int p, input bit we, input int addr, input logic [DW-1:0] wd);
        if (p == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = AW'(addr); p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = AW'(addr); p1_wdata = wd;
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance model, step the clock.
    task automatic tick();
        bit e_done0, e_done1, in_access;
        int win;
        @(negedge clk);
        e_done0 = pend_valid && cyc == pend_due && pend_port == 0;
        e_done1 = pend_valid && cyc == pend_due && pend_port == 1;
        if (pend_valid && cyc == pend_due) begin
            if (!pend_we) exp_rdata[pend_port] = pend_rdata;
            pend_valid = 1'b0;
        end
        in_access = pend_valid && cyc == pend_due - 1;
        chk("p0_done", 64'(p0_done), 64'(e_done0));
        chk("p1_done", 64'(p1_done), 64'(e_done1));
        chk("p0_rdata", 64'(p0_rdata), 64'(exp_rdata[0]));
        chk("p1_rdata", 64'(p1_rdata), 64'(exp_rdata[1]));
        chk("mem_read", 64'(mem_read), 64'(in_access && pend_we));
        if (in_access) begin
            chk("mem_address", 64'(mem_address), 64'(pend_addr));
            chk("mem_in", 64'(mem_in), pend_we ? 64'(pend_wdata) : 64'd0);
        end else begin
            chk("mem_in_idle", 64'(mem_in), 64'd0);
        end
        win = -1;
        if (!pend_valid) begin
            if (p0_req && p1_req) win = (last_grant == 0) ? 1 : 0;
            else if (p0_req)      win = 0;
            else if (p1_req)      win = 1;
        end
        chk("p0_ready", 64'(p0_ready), 64'(win == 0));
        chk("p1_ready", 64'(p1_ready), 64'(win == 1));
        if (p0_ready) grants.push_back(0);
        if (p1_ready) grants.push_back(1);
        if (win >= 0) begin
            pend_valid = 1'b1;
            pend_due   = cyc + 2;
            pend_port  = win;
            pend_we    = (win == 1) ? p1_we : p0_we;
            pend_addr  = (win == 1) ? p1_addr : p0_addr;
            pend_wdata = (win == 1) ? p1_wdata : p0_wdata;
            if (pend_we) ref_mem[pend_addr] = pend_wdata;
            else         pend_rdata = ref_mem[pend_addr];
            last_grant = win;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (win == 0) p0_req = 1'b0;
        if (win == 1) p1_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        chk("rst_mem_in", 64'(mem_in), 64'd0);
        chk("rst_done", 64'({p0_done, p1_done}), 64'd0);
        chk("rst_p0_rdata", 64'(p0_rdata), 64'd0);
        chk("rst_p1_rdata", 64'(p1_rdata), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_mem_read", 64'(mem_read), 64'd0);
        pend_valid   = 1'b0;
        last_grant   = 1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]     <= DW'(i);
            ref_mem[i] = DW'(i);
        end
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        #2;
        do_reset();
        repeat (3) tick();

        // Single read from port 0
        set_req(0, 1'b0, 5, '0);
        repeat (4) tick();
        chk("single_read_rdata", 64'(p0_rdata), 64'd5);

        // Port 1 writes, port 0 reads it back
        set_req(1, 1'b1, 10, 32'hDEADBEEF);
        repeat (3) tick();
        set_req(0, 1'b0, 10, '0);
        repeat (3) tick();
        chk("write_readback", 64'(p0_rdata), 64'hDEADBEEF);

        // Arbitration from reset with both ports held
        do_reset();
        grants.delete();
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 2, '0);
        repeat (6) begin
            tick();
            if (!p0_req) set_req(0, 1'b0, 1, '0);
            if (!p1_req) set_req(1, 1'b0, 2, '0);
        end
        chk("arb_count", 64'(grants.size()), 64'd3);
        chk("arb_first", 64'(grants[0]), 64'd0);
        chk("arb_second", 64'(grants[1]), 64'd1);
        chk("arb_third", 64'(grants[2]), 64'd0);
        tick();
        p0_req = 1'b0;
        if (!p1_req) set_req(1, 1'b0, 2, '0);
        repeat (4) tick();
        chk("arb_solo_count", 64'(grants.size()), 64'd5);
        chk("arb_solo_p1a", 64'(grants[3]), 64'd1);
        chk("arb_solo_p1b", 64'(grants[4]), 64'd1);

        // Back-to-back reads on port 0
        grants.delete();
        set_req(0, 1'b0, 20, '0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (!p0_req && k < 4) set_req(0, 1'b0, 21 + k / 2, '0);
        end
        repeat (2) tick();
        chk("b2b_count", 64'(grants.size()), 64'd3);
        chk("b2b_last_rdata", 64'(p0_rdata), 64'd22);

        // Reset during the ACCESS of a port-1 read
        set_req(1, 1'b0, 3, '0);
        tick();
        set_req(0, 1'b0, 7, '0);
        set_req(1, 1'b0, 4, '0);
        do_reset();
        grants.delete();
        tick();
        chk("post_reset_grant_count", 64'(grants.size()), 64'd1);
        chk("post_reset_grant_p0", 64'(grants[0]), 64'd0);
        p1_req = 1'b0;
        repeat (3) tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if (!p0_req) begin
                if ($urandom_range(1, 0) == 1)
                    set_req(0, 1'($urandom_range(1, 0)), int'($urandom_range(31, 0)), DW'($urandom));
            end else if ($urandom_range(7, 0) == 0) p0_req = 1'b0;
            if (!p1_req) begin
                if ($urandom_range(1, 0) == 1)
                    set_req(1, 1'($urandom_range(1, 0)), int'($urandom_range(31, 0)), DW'($urandom));
            end else if ($urandom_range(7, 0) == 0) p1_req = 1'b0;
            tick();
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
